// File: rtl/pid_pkg.sv
// Shared widths and the output saturation helper for the PD velocity regulator.
package pid_pkg;

    localparam int VEL_W  = 8;
    localparam int GAIN_W = 4;
    localparam int ERR_W  = 9;
    localparam int DERR_W = 10;
    localparam int ACC_W  = 16;

    // Clamp a signed accumulator to the unsigned 8-bit command range.
    function automatic logic [VEL_W-1:0] sat_u8(input logic signed [ACC_W-1:0] val);
        logic [VEL_W-1:0] res;
        if (val < 0) begin
            res = '0;
        end else if (val > 16'sd255) begin
            res = '1;
        end else begin
            res = val[VEL_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pid_pd_core.sv
// Combinational PD datapath: error, error delta, weighted sum, shift and
// the unsaturated next command.
module pid_pd_core
    import pid_pkg::*;
#(
    parameter int SETPOINT = 128,
    parameter int FRAC     = 2
) (
    input  logic [VEL_W-1:0]         current_vel,
    input  logic [GAIN_W-1:0]        kp,
    input  logic [GAIN_W-1:0]        kd,
    input  logic signed [ERR_W-1:0]  e_prev,
    output logic signed [ERR_W-1:0]  err,
    output logic signed [ACC_W-1:0]  y
);

    localparam logic [VEL_W-1:0] SETPOINT_U = VEL_W'(SETPOINT);

    logic signed [DERR_W-1:0] d;
    logic signed [ACC_W-1:0]  e_x;
    logic signed [ACC_W-1:0]  d_x;
    logic signed [ACC_W-1:0]  kp_x;
    logic signed [ACC_W-1:0]  kd_x;
    logic signed [ACC_W-1:0]  u;
    logic signed [ACC_W-1:0]  s;

    always_comb begin
        err  = $signed({1'b0, SETPOINT_U}) - $signed({1'b0, current_vel});
        d    = $signed({err[ERR_W-1], err}) - $signed({e_prev[ERR_W-1], e_prev});
        // Everything is widened to the accumulator width up front so the
        // products and the sum cannot wrap.
        e_x  = $signed({{(ACC_W-ERR_W){err[ERR_W-1]}}, err});
        d_x  = $signed({{(ACC_W-DERR_W){d[DERR_W-1]}}, d});
        kp_x = $signed({{(ACC_W-GAIN_W){1'b0}}, kp});
        kd_x = $signed({{(ACC_W-GAIN_W){1'b0}}, kd});
        u    = kp_x * e_x + kd_x * d_x;
        s    = u >>> FRAC;
        y    = s + $signed({{(ACC_W-VEL_W){1'b0}}, current_vel});
    end

endmodule

// File: rtl/pid_controller.sv
// PD velocity regulator: holds the previous error and the saturated,
// registered velocity command; updates only on enabled edges.
module pid_controller
    import pid_pkg::*;
#(
    parameter int SETPOINT = 128,
    parameter int FRAC     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [VEL_W-1:0]  current_vel,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] kd,
    output logic [VEL_W-1:0]  vel_output
);

    logic signed [ERR_W-1:0] e_prev_q;
    logic signed [ERR_W-1:0] e_prev_d;
    logic [VEL_W-1:0]        vel_q;
    logic [VEL_W-1:0]        vel_d;
    logic signed [ERR_W-1:0] err;
    logic signed [ACC_W-1:0] y;

    pid_pd_core #(
        .SETPOINT (SETPOINT),
        .FRAC     (FRAC)
    ) u_core (
        .current_vel (current_vel),
        .kp          (kp),
        .kd          (kd),
        .e_prev      (e_prev_q),
        .err         (err),
        .y           (y)
    );

    // The stored error is the raw error, independent of saturation.
    always_comb begin
        e_prev_d = e_prev_q;
        vel_d    = vel_q;
        if (ce) begin
            e_prev_d = err;
            vel_d    = sat_u8(y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_prev_q <= '0;
            vel_q    <= '0;
        end else begin
            e_prev_q <= e_prev_d;
            vel_q    <= vel_d;
        end
    end

    assign vel_output = vel_q;

endmodule

// File: tb/tb_pid_controller.sv
// Directed bench for pid_controller with hand-computed expected commands
// (SETPOINT=128, FRAC=2).
module tb_pid_controller;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [7:0] current_vel;
    logic [3:0] kp;
    logic [3:0] kd;
    logic [7:0] vel_output;

    int vectors;
    int miscompares;

    pid_controller #(
        .SETPOINT (128),
        .FRAC     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .current_vel (current_vel),
        .kp          (kp),
        .kd          (kd),
        .vel_output  (vel_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] expected);
        vectors++;
        assert (vel_output === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, vel_output, expected);
        end
        $display("vec %0d %s: vel_output=%0d expected=%0d", vectors, tag, vel_output, expected);
    endtask

    task automatic set_in(input logic c, input logic [7:0] v, input logic [3:0] p, input logic [3:0] d);
        ce          = c;
        current_vel = v;
        kp          = p;
        kd          = d;
    endtask

    task automatic edge_check(input string tag, input logic [7:0] expected);
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    // Reset pulse placed between clock edges, checked while still asserted.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(tag, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        set_in(1'b1, 8'd5, 4'd3, 4'd4);
        #1;
        check("reset_initial", 8'd0);
        edge_check("reset_held_over_edge", 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Disabled edge right after reset: nothing moves.
        set_in(1'b0, 8'd5, 4'd3, 4'd4);
        edge_check("ce0_after_reset", 8'd0);

        // e=123 d=123 u=861 s=215 -> 220; then d=0 u=369 s=92 -> 97.
        ce = 1'b1;
        edge_check("first_edge", 8'd220);
        edge_check("steady_1", 8'd97);
        edge_check("steady_2", 8'd97);

        // Five disabled cycles with moving inputs.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 8'(50 + 30 * i), 4'(i + 1), 4'(15 - i));
            edge_check($sformatf("ce_gap_%0d", i), 8'd97);
        end

        // e=28, e_prev still 123: d=-95 u=-296 s=-74 -> 26.
        set_in(1'b1, 8'd100, 4'd3, 4'd4);
        edge_check("resume_uses_old_eprev", 8'd26);

        // e_prev=28: e=123 d=95 u=749 s=187 -> 192; then 97.
        set_in(1'b1, 8'd5, 4'd3, 4'd4);
        edge_check("back_to_5_first", 8'd192);
        edge_check("back_to_5_steady", 8'd97);

        do_reset("async_reset_midcycle");
        edge_check("first_after_async_reset", 8'd220);

        // e=-72 u=-144 s=-36 -> 164.
        do_reset("reset_b");
        set_in(1'b1, 8'd200, 4'd2, 4'd0);
        edge_check("p_only_neg_err", 8'd164);
        edge_check("p_only_neg_err_2", 8'd164);

        // u=3840 y=960 -> 255; u=1920 y=480 -> 255.
        do_reset("reset_c");
        set_in(1'b1, 8'd0, 4'd15, 4'd15);
        edge_check("clamp_high_1", 8'd255);
        edge_check("clamp_high_2", 8'd255);

        // e=-127 u=-3810 s=-953 y=-698 -> 0; then u=-1905 s=-477 y=-222 -> 0.
        do_reset("reset_d");
        set_in(1'b1, 8'd255, 4'd15, 4'd15);
        edge_check("clamp_low_1", 8'd0);
        edge_check("clamp_low_2", 8'd0);

        // Zero gains pass the measurement straight through.
        set_in(1'b1, 8'd77, 4'd0, 4'd0);
        edge_check("zero_gain_77", 8'd77);
        set_in(1'b1, 8'd0, 4'd0, 4'd0);
        edge_check("zero_gain_0", 8'd0);
        set_in(1'b1, 8'd255, 4'd0, 4'd0);
        edge_check("zero_gain_255", 8'd255);

        // Gain changes take effect on the next enabled edge.
        do_reset("reset_e");
        set_in(1'b1, 8'd5, 4'd3, 4'd4);
        edge_check("gain_seq_first", 8'd220);
        set_in(1'b1, 8'd5, 4'd0, 4'd0);
        edge_check("gain_seq_zero", 8'd5);
        // e=123 u=123 s=30 -> 35.
        set_in(1'b1, 8'd5, 4'd1, 4'd0);
        edge_check("gain_seq_kp1", 8'd35);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pid_controller.md
Name: pid_controller

Overview:
- Fixed-point PD velocity regulator.
- Compares the measured speed `current_vel` against a fixed setpoint and applies proportional and derivative gains supplied at runtime.
- Produces a saturated 8-bit velocity command for the BLDC commutation/PWM stage.
- Updates only on clock edges where the clock-enable `ce` is high.

Parameters:
- SETPOINT, 128: target velocity, unsigned 8-bit.
- FRAC, 2: right arithmetic shift applied to the gain sum; gains have a FRAC-bit fraction.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; update happens only when high.
- current_vel  input  8  measured velocity, unsigned.
- kp  input  4  proportional gain, unsigned.
- kd  input  4  derivative gain, unsigned.
- vel_output  output  8  velocity command, unsigned, registered.

Behaviour:
- Reset (rst_n low, asynchronous): vel_output=0, e_prev=0. Both hold until rst_n is high and the next rising clk edge with ce=1.
- Combinational, per cycle:
  - e = SETPOINT - current_vel, 9-bit signed, range -255..255.
  - d = e - e_prev, 10-bit signed.
  - u = kp*e + kd*d. Gains are zero-extended to signed; u is at least 15-bit signed, with no overflow possible.
  - s = u >>> FRAC. Arithmetic shift, i.e. floor toward -inf; no rounding.
  - y = current_vel + s, at least 16-bit signed.
  - y is clamped to 0..255.
- Rising clk with ce=1: vel_output <= clamp(y); e_prev <= e.
- Rising clk with ce=0: vel_output and e_prev hold. Input changes have no effect.
- Latency: one cycle. vel_output reflects the inputs sampled at the last enabled edge.
- Boundaries:
  - kp=kd=0: vel_output = current_vel.
  - y>255 gives 255; y<0 gives 0.
  - Saturation does not affect e_prev; there is no integrator, so no windup.
- Reset asserted mid-operation clears the state immediately. The first enabled edge after reset uses e_prev=0, so d=e.
- Gains may change on any cycle and take effect at the next enabled edge.
- No X propagation: all registers are reset.

Decomposition:
- Package pid_pkg holds:
  - constants VEL_W=8, GAIN_W=4, ERR_W=9, DERR_W=10, ACC_W=16;
  - a function sat_u8(signed ACC_W) returning an 8-bit value.
- One natural sub-module, pid_pd_core: purely combinational e/d/u/y computation.
- The top level holds the e_prev and vel_output registers, ce gating and saturation.

Test Plan (SETPOINT=128, FRAC=2):
- Reset, then ce=1, current_vel=5, kp=3, kd=4 -> first edge vel_output=220 (e=123, d=123, u=861, s=215); second and later edges 97 (d=0, u=369, s=92).
- From reset, current_vel=200, kp=2, kd=0 -> vel_output=164 (e=-72, u=-144, s=-36).
- From reset, current_vel=0, kp=15, kd=15 -> first edge u=3840, y=960 -> 255; next edge u=1920, y=480 -> 255 (high clamp).
- From reset, current_vel=255, kp=15, kd=15 -> e=-127, u=-3810, s=-953 (floor), y<0 -> vel_output=0 (low clamp).
- ce=0 for 5 cycles while inputs change -> vel_output and e_prev unchanged. ce back to 1 -> update uses the e_prev held from before the gap.
- Assert rst_n low asynchronously between clock edges while vel_output=97 -> vel_output=0 immediately, before the next edge. Release -> the next enabled edge behaves as the first edge after reset (220 for the first-scenario inputs).
